limber_gnrl_ramtdp_arb: RTL and testbench
=========================================

// Module: limber_gnrl_ramtdp_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one true dual-port RAM (limber_gnrl_ramtdp) among NREQ requesters.
//  Grants up to two requests per cycle, one on RAM port A and one on port B, and drives the RAM ports.
//  Tracks in-flight reads through a DLY-deep tag pipeline and routes each read result to its requester.
//  Sits between bus-side masters (e.g. core LSU, DMA) and the RAM macro; it contains no storage array itself.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  DP    16  RAM depth, words
//  DW    32  data width
//  AW    4   address width, clog2(DP)
//  DLY   1   RAM read latency in clk cycles (>=1); must equal the RAM's DLY
// PORTS
//  clk        in   1        clock; all logic on posedge
//  rst        in   1        synchronous reset, active-high
//  req_vld    in   NREQ     request valid, one bit per requester
//  req_we     in   NREQ     1 = write, 0 = read
//  req_addr   in   NREQ*AW  request address, requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  write data, requester i at [i*DW +: DW]
//  req_rdy    out  NREQ     request accepted this cycle (combinational)
//  rsp_vld    out  NREQ     read data valid, 1-cycle pulse per accepted read
//  rsp_data   out  NREQ*DW  read data, requester i at [i*DW +: DW]
//  ram_cs     out  1        RAM chip select
//  ram_addra  out  AW       port A address;   ram_addrb  out  AW  port B address
//  ram_wa     out  1        port A write;     ram_wb     out  1   port B write
//  ram_dina   out  DW       port A write data; ram_dinb  out  DW  port B write data
//  ram_douta  in   DW       port A read data; ram_doutb  in   DW  port B read data
// BEHAVIOUR
//  Handshake: request i is accepted in a cycle with req_vld[i] & req_rdy[i]; requester holds
//   vld/we/addr/wdata stable until accepted. req_rdy depends on req_vld, ptr, req_we, req_addr only.
//  Arbitration, combinational each cycle, registered pointer ptr (0..NREQ-1):
//   - grant A = first i with req_vld[i], searching ptr, ptr+1, ... modulo NREQ.
//   - grant B = next valid index after grant A in the same circular order, never equal to grant A.
//   - conflict: grant A and grant B both writes to the same address -> grant B dropped this cycle.
//   - ptr <= (last granted index + 1) mod NREQ; unchanged when nothing is granted.
//  RAM drive: ram_cs = any grant; ram_addrX/ram_wX/ram_dinX from the grantee; ram_wX=0 and ram_dinX=0
//   with no grant on that port; all ram_* outputs are 0 when idle or while rst is high.
//  Read tag pipeline: per port a DLY-stage shift of {valid, requester index}; a read accepted in
//   cycle t gives rsp_vld[i]=1 in cycle t+DLY with rsp_data[i] = ram_doutX of the granted port.
//   Writes produce no response. Two reads by the same requester in one cycle are impossible (one grant each).
//  Read-during-write, same address, same cycle (either port pairing): the read returns the old word.
//  Responses return in acceptance order per requester; no backpressure on rsp (always taken).
//  rsp_data[i] holds its last value when rsp_vld[i]=0; reset value 0.
//  Reset (rst=1, sampled at posedge): ptr<=0, all tag stages invalid, rsp_vld<=0, rsp_data<=0;
//   req_rdy=0 while rst is high. Reads in flight when rst asserts are discarded (no rsp_vld later).
//  Throughput: 2 accesses/cycle sustained without same-address write pairs; no bubbles between grants.
// TESTING
//  1 req0 write addr 3 = 0xA5A5_0001, then req0 read addr 3 -> rsp_vld[0] DLY cycles later, data 0xA5A5_0001.
//  2 req0..3 all read at once, ptr=0 -> cycle0 rdy=0011 (A=0,B=1), cycle1 rdy=1100; rsp pairs at +DLY.
//  3 req1 and req2 write addr 5 (0x11, 0x22) together -> only req1 accepted; req2 next cycle; final mem[5]=0x22.
//  4 req0 writes addr 7 = 0x55 while req1 reads addr 7 (old 0x33) -> rsp_data[1]=0x33; next read returns 0x55.
//  5 req0,req1,req2 held valid 6 cycles -> grant pairs (0,1),(2,0),(1,2)...; no requester starved >1 cycle.
//  6 rst asserted the cycle after a read is accepted -> no rsp_vld pulse; ptr=0; all ram_* outputs 0.

Source files
------------

// File: rtl/limber_gnrl_ramtdp_arb.sv
// ---------------------------------------------------------------------------
// limber_gnrl_ramtdp_arb
//
// Round-robin arbiter/sequencer that shares one true dual-port RAM
// (limber_gnrl_ramtdp) among NREQ requesters. Each cycle it grants up to two
// requests: the first on RAM port A and the next one, in circular order, on
// port B. It drives the RAM ports directly and tracks in-flight reads through
// a DLY-deep tag pipeline per port, so each read result is routed back to
// the requester that issued it. It holds no storage array of its own.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_vld/we/addr/wdata per-requester request; requester i at slice i
//   req_rdy               request accepted this cycle (combinational)
//   rsp_vld/rsp_data      read response; rsp_data holds while rsp_vld is low
//   ram_cs                RAM chip select (any grant this cycle)
//   ram_addra/wa/dina     RAM port A address / write enable / write data
//   ram_addrb/wb/dinb     RAM port B address / write enable / write data
//   ram_douta/doutb       RAM read data, DLY cycles after the access
// ---------------------------------------------------------------------------
module limber_gnrl_ramtdp_arb #(
    parameter int NREQ = 4,
    parameter int DP   = 16,
    parameter int DW   = 32,
    parameter int AW   = 4,
    parameter int DLY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_rdy,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [NREQ*DW-1:0]   rsp_data,
    output logic                 ram_cs,
    output logic [AW-1:0]        ram_addra,
    output logic [AW-1:0]        ram_addrb,
    output logic                 ram_wa,
    output logic                 ram_wb,
    output logic [DW-1:0]        ram_dina,
    output logic [DW-1:0]        ram_dinb,
    input  logic [DW-1:0]        ram_douta,
    input  logic [DW-1:0]        ram_doutb
);

    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    // Reject parameter sets the pointer/tag logic cannot represent.
    if (NREQ < 2 || NREQ > 8 || DLY < 1 || DP > (1 << AW)) begin : g_param_chk
        $error("limber_gnrl_ramtdp_arb: illegal parameter set");
    end

    // Reduce an index in 0..2*NREQ-2 back into 0..NREQ-1.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW:0] v);
        logic [IW:0] r;
        if (v >= NREQ_W) begin
            r = v - NREQ_W;
        end else begin
            r = v;
        end
        return r[IW-1:0];
    endfunction

    logic [AW-1:0] addr_s     [NREQ];
    logic [DW-1:0] wdata_s    [NREQ];
    logic [DW-1:0] rsp_data_s [NREQ];
    logic [DW-1:0] rsp_data_r [NREQ];

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] ptr_nxt_s;

    logic          gnt_a_s;
    logic [IW-1:0] gnt_a_idx_s;
    logic          gnt_b_raw_s;
    logic          gnt_b_s;
    logic [IW-1:0] gnt_b_idx_s;
    logic          wr_conflict_s;

    logic [DLY-1:0] tag_a_vld_r;
    logic [DLY-1:0] tag_b_vld_r;
    logic [IW-1:0]  tag_a_idx_r [DLY];
    logic [IW-1:0]  tag_b_idx_r [DLY];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign addr_s[gi]              = req_addr[gi*AW +: AW];
        assign wdata_s[gi]             = req_wdata[gi*DW +: DW];
        assign rsp_data[gi*DW +: DW]   = rsp_data_s[gi];
    end

    // Circular search from ptr: first valid requester -> port A, next -> port B.
    always_comb begin
        logic [IW-1:0] cand_v;
        cand_v      = '0;
        gnt_a_s     = 1'b0;
        gnt_a_idx_s = '0;
        gnt_b_raw_s = 1'b0;
        gnt_b_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_v = wrap_idx({1'b0, ptr_r} + (IW+1)'(k));
            if (req_vld[cand_v] && !rst) begin
                if (!gnt_a_s) begin
                    gnt_a_s     = 1'b1;
                    gnt_a_idx_s = cand_v;
                end else if (!gnt_b_raw_s) begin
                    gnt_b_raw_s = 1'b1;
                    gnt_b_idx_s = cand_v;
                end else begin
                    gnt_b_raw_s = gnt_b_raw_s;
                end
            end else begin
                cand_v = cand_v;
            end
        end
    end

    // Two writes to one address in the same cycle would race inside the RAM,
    // so port B yields and retries next cycle.
    always_comb begin
        wr_conflict_s = 1'b0;
        if (gnt_a_s && gnt_b_raw_s) begin
            wr_conflict_s = req_we[gnt_a_idx_s] && req_we[gnt_b_idx_s] &&
                            (addr_s[gnt_a_idx_s] == addr_s[gnt_b_idx_s]);
        end else begin
            wr_conflict_s = 1'b0;
        end
        gnt_b_s = gnt_b_raw_s && !wr_conflict_s;
    end

    // Drive handshake and RAM ports from the final grants; zero when idle.
    always_comb begin
        req_rdy   = '0;
        ram_addra = '0;
        ram_wa    = 1'b0;
        ram_dina  = '0;
        ram_addrb = '0;
        ram_wb    = 1'b0;
        ram_dinb  = '0;
        if (gnt_a_s) begin
            req_rdy[gnt_a_idx_s] = 1'b1;
            ram_addra            = addr_s[gnt_a_idx_s];
            ram_wa               = req_we[gnt_a_idx_s];
            ram_dina             = wdata_s[gnt_a_idx_s];
        end else begin
            ram_wa = 1'b0;
        end
        if (gnt_b_s) begin
            req_rdy[gnt_b_idx_s] = 1'b1;
            ram_addrb            = addr_s[gnt_b_idx_s];
            ram_wb               = req_we[gnt_b_idx_s];
            ram_dinb             = wdata_s[gnt_b_idx_s];
        end else begin
            ram_wb = 1'b0;
        end
        ram_cs = gnt_a_s || gnt_b_s;
    end

    // Next pointer: one past the last granted index (port B when it won).
    always_comb begin
        if (gnt_b_s) begin
            ptr_nxt_s = wrap_idx({1'b0, gnt_b_idx_s} + (IW+1)'(1));
        end else if (gnt_a_s) begin
            ptr_nxt_s = wrap_idx({1'b0, gnt_a_idx_s} + (IW+1)'(1));
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Read tag pipelines: stage DLY-1 lines up with the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_a_vld_r <= '0;
            tag_b_vld_r <= '0;
            for (int s = 0; s < DLY; s++) begin
                tag_a_idx_r[s] <= '0;
                tag_b_idx_r[s] <= '0;
            end
        end else begin
            tag_a_vld_r[0] <= gnt_a_s && !req_we[gnt_a_idx_s];
            tag_a_idx_r[0] <= gnt_a_idx_s;
            tag_b_vld_r[0] <= gnt_b_s && !req_we[gnt_b_idx_s];
            tag_b_idx_r[0] <= gnt_b_idx_s;
            for (int s = 1; s < DLY; s++) begin
                tag_a_vld_r[s] <= tag_a_vld_r[s-1];
                tag_a_idx_r[s] <= tag_a_idx_r[s-1];
                tag_b_vld_r[s] <= tag_b_vld_r[s-1];
                tag_b_idx_r[s] <= tag_b_idx_r[s-1];
            end
        end
    end

    // Route returning read data to its requester; otherwise hold the last word.
    // A requester owns at most one port per acceptance cycle, so A and B never
    // target the same requester in one cycle.
    always_comb begin
        rsp_vld = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_data_s[i] = rsp_data_r[i];
            if (!rst && tag_a_vld_r[DLY-1] && (tag_a_idx_r[DLY-1] == IW'(i))) begin
                rsp_vld[i]    = 1'b1;
                rsp_data_s[i] = ram_douta;
            end else if (!rst && tag_b_vld_r[DLY-1] && (tag_b_idx_r[DLY-1] == IW'(i))) begin
                rsp_vld[i]    = 1'b1;
                rsp_data_s[i] = ram_doutb;
            end else begin
                rsp_data_s[i] = rsp_data_r[i];
            end
        end
    end

    // Response data holding register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                rsp_data_r[i] <= '0;
            end else begin
                rsp_data_r[i] <= rsp_data_s[i];
            end
        end
    end

endmodule

// File: tb/tb_limber_gnrl_ramtdp_arb.sv
// ---------------------------------------------------------------------------
// tb_limber_gnrl_ramtdp_arb
//
// Scoreboard bench: per-requester operation queues drive the request ports,
// a reference arbiter and shadow memory predict grants and read data, and
// expected responses are queued with their due cycle and popped when the
// DUT responds. A behavioural read-first dual-port RAM closes the loop.
// ---------------------------------------------------------------------------
module tb_limber_gnrl_ramtdp_arb;

    localparam int NREQ = 4;
    localparam int DP   = 16;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int DLY  = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ-1:0]      rsp_vld;
    logic [NREQ*DW-1:0]   rsp_data;
    logic                 ram_cs;
    logic [AW-1:0]        ram_addra;
    logic [AW-1:0]        ram_addrb;
    logic                 ram_wa;
    logic                 ram_wb;
    logic [DW-1:0]        ram_dina;
    logic [DW-1:0]        ram_dinb;
    logic [DW-1:0]        ram_douta;
    logic [DW-1:0]        ram_doutb;

    limber_gnrl_ramtdp_arb #(
        .NREQ(NREQ), .DP(DP), .DW(DW), .AW(AW), .DLY(DLY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .ram_cs    (ram_cs),
        .ram_addra (ram_addra),
        .ram_addrb (ram_addrb),
        .ram_wa    (ram_wa),
        .ram_wb    (ram_wb),
        .ram_dina  (ram_dina),
        .ram_dinb  (ram_dinb),
        .ram_douta (ram_douta),
        .ram_doutb (ram_doutb)
    );

    always #5 clk = ~clk;

    // Behavioural read-first true dual-port RAM with DLY-cycle read latency.
    logic [DW-1:0] mem    [DP];
    logic [DW-1:0] pipe_a [DLY];
    logic [DW-1:0] pipe_b [DLY];

    always @(posedge clk) begin
        if (ram_cs && !ram_wa) pipe_a[0] <= mem[ram_addra];
        if (ram_cs && !ram_wb) pipe_b[0] <= mem[ram_addrb];
        if (ram_cs && ram_wa)  mem[ram_addra] <= ram_dina;
        if (ram_cs && ram_wb)  mem[ram_addrb] <= ram_dinb;
        for (int s = 1; s < DLY; s++) begin
            pipe_a[s] <= pipe_a[s-1];
            pipe_b[s] <= pipe_b[s-1];
        end
    end
    assign ram_douta = pipe_a[DLY-1];
    assign ram_doutb = pipe_b[DLY-1];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    op_t           opq    [NREQ][$];
    exp_t          rspq   [NREQ][$];
    logic [DW-1:0] shadow [DP];
    logic [DW-1:0] held   [NREQ];
    int            wait_cnt [NREQ];
    int            max_wait;
    int            ptr_m;
    int            cyc;
    int            n_chk;
    int            n_fail;
    logic [NREQ-1:0] last_rdy;
    logic            last_ram_any;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_op(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        op_t o;
        o.we    = we;
        o.addr  = addr;
        o.wdata = wdata;
        opq[i].push_back(o);
    endtask

    function automatic logic busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (opq[i].size() > 0 || rspq[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    // One clock cycle: drive heads of the op queues, check at negedge, advance.
    task automatic run_cycle(input logic rst_v);
        int              ga;
        int              gb;
        int              j;
        logic [NREQ-1:0] vld_v;
        logic [NREQ-1:0] we_v;
        logic [AW-1:0]   ad_v [NREQ];
        logic [DW-1:0]   wd_v [NREQ];
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        logic [36:0]     exp_pa;
        logic [36:0]     exp_pb;
        exp_t            e;

        rst = rst_v;
        for (int i = 0; i < NREQ; i++) begin
            if (opq[i].size() > 0) begin
                vld_v[i] = 1'b1;
                we_v[i]  = opq[i][0].we;
                ad_v[i]  = opq[i][0].addr;
                wd_v[i]  = opq[i][0].wdata;
            end else begin
                vld_v[i] = 1'b0;
                we_v[i]  = 1'b0;
                ad_v[i]  = '0;
                wd_v[i]  = '0;
            end
            req_vld[i]              = vld_v[i];
            req_we[i]               = we_v[i];
            req_addr[i*AW +: AW]    = ad_v[i];
            req_wdata[i*DW +: DW]   = wd_v[i];
        end

        @(negedge clk);

        for (int i = 0; i < NREQ; i++) begin
            exp_rv = !rst_v && (rspq[i].size() > 0) && (rspq[i][0].due == cyc);
            check_val($sformatf("rsp_vld[%0d]", i), 64'(rsp_vld[i]), 64'(exp_rv));
            if (exp_rv) begin
                held[i] = rspq[i][0].data;
                void'(rspq[i].pop_front());
            end
            check_val($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'(held[i]));
        end

        ga = -1;
        gb = -1;
        if (!rst_v) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (ptr_m + k) % NREQ;
                if (vld_v[j]) begin
                    if (ga < 0) ga = j;
                    else if (gb < 0) gb = j;
                end
            end
        end
        if (ga >= 0 && gb >= 0 && we_v[ga] && we_v[gb] && ad_v[ga] == ad_v[gb]) gb = -1;

        exp_rdy = '0;
        exp_pa  = '0;
        exp_pb  = '0;
        if (ga >= 0) begin
            exp_rdy[ga] = 1'b1;
            exp_pa      = {we_v[ga], ad_v[ga], wd_v[ga]};
        end
        if (gb >= 0) begin
            exp_rdy[gb] = 1'b1;
            exp_pb      = {we_v[gb], ad_v[gb], wd_v[gb]};
        end
        check_val("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        check_val("ram_cs", 64'(ram_cs), 64'(ga >= 0));
        check_val("ram_port_a", 64'({ram_wa, ram_addra, ram_dina}), 64'(exp_pa));
        check_val("ram_port_b", 64'({ram_wb, ram_addrb, ram_dinb}), 64'(exp_pb));
        last_rdy     = req_rdy;
        last_ram_any = |{ram_cs, ram_wa, ram_wb, ram_addra, ram_addrb, ram_dina, ram_dinb};

        for (int i = 0; i < NREQ; i++) begin
            if (vld_v[i] && !req_rdy[i]) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end else begin
                wait_cnt[i] = 0;
            end
        end

        // Reads see the memory as it was before this cycle's writes.
        if (ga >= 0 && !we_v[ga]) begin
            e.due = cyc + DLY; e.data = shadow[ad_v[ga]]; rspq[ga].push_back(e);
        end
        if (gb >= 0 && !we_v[gb]) begin
            e.due = cyc + DLY; e.data = shadow[ad_v[gb]]; rspq[gb].push_back(e);
        end
        if (ga >= 0 && we_v[ga]) shadow[ad_v[ga]] = wd_v[ga];
        if (gb >= 0 && we_v[gb]) shadow[ad_v[gb]] = wd_v[gb];

        if (gb >= 0)      ptr_m = (gb + 1) % NREQ;
        else if (ga >= 0) ptr_m = (ga + 1) % NREQ;
        if (rst_v) begin
            ptr_m = 0;
            for (int i = 0; i < NREQ; i++) begin
                rspq[i].delete();
                held[i] = '0;
            end
        end

        @(posedge clk);
        #1;
        if (ga >= 0) void'(opq[ga].pop_front());
        if (gb >= 0) void'(opq[gb].pop_front());
        cyc++;
    endtask

    task automatic run_phase(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            run_cycle(1'b0);
            n++;
        end
        check_val("phase_drain", 64'(busy()), 64'd0);
    endtask

    task automatic do_reset();
        run_cycle(1'b1);
        run_cycle(1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        ptr_m     = 0;
        max_wait  = 0;
        rst       = 1'b1;
        req_vld   = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            held[i]     = '0;
            wait_cnt[i] = 0;
        end

        do_reset();

        // 1: write then read back through req0; preload data for later tests.
        push_op(0, 1'b1, 4'd3,  32'hA5A5_0001);
        push_op(0, 1'b0, 4'd3,  32'h0000_0000);
        push_op(1, 1'b1, 4'd8,  32'h1111_0008);
        push_op(1, 1'b1, 4'd7,  32'h0000_0033);
        push_op(2, 1'b1, 4'd9,  32'h2222_0009);
        push_op(3, 1'b1, 4'd10, 32'h3333_000A);
        push_op(3, 1'b1, 4'd11, 32'h4444_000B);
        run_phase(40);
        check_val("t1_rdata", 64'(rsp_data[0*DW +: DW]), 64'(32'hA5A5_0001));

        // 2: all four read at once from ptr 0.
        do_reset();
        push_op(0, 1'b0, 4'd8,  32'hDEAD_0000);
        push_op(1, 1'b0, 4'd9,  32'hDEAD_0001);
        push_op(2, 1'b0, 4'd10, 32'hDEAD_0002);
        push_op(3, 1'b0, 4'd11, 32'hDEAD_0003);
        run_cycle(1'b0);
        check_val("t2_rdy_c0", 64'(last_rdy), 64'(4'b0011));
        run_cycle(1'b0);
        check_val("t2_rdy_c1", 64'(last_rdy), 64'(4'b1100));
        run_phase(20);
        check_val("t2_rdata3", 64'(rsp_data[3*DW +: DW]), 64'(32'h4444_000B));

        // 3: same-address write pair; port B yields.
        do_reset();
        push_op(1, 1'b1, 4'd5, 32'h0000_0011);
        push_op(2, 1'b1, 4'd5, 32'h0000_0022);
        run_cycle(1'b0);
        check_val("t3_rdy_c0", 64'(last_rdy), 64'(4'b0010));
        run_cycle(1'b0);
        check_val("t3_rdy_c1", 64'(last_rdy), 64'(4'b0100));
        run_phase(20);
        push_op(3, 1'b0, 4'd5, 32'h0000_0000);
        run_phase(20);
        check_val("t3_final", 64'(rsp_data[3*DW +: DW]), 64'(32'h0000_0022));

        // 4: read-during-write on the same address returns the old word.
        do_reset();
        push_op(0, 1'b1, 4'd7, 32'h0000_0055);
        push_op(1, 1'b0, 4'd7, 32'h0000_0000);
        run_phase(20);
        check_val("t4_old", 64'(rsp_data[1*DW +: DW]), 64'(32'h0000_0033));
        push_op(1, 1'b0, 4'd7, 32'h0000_0000);
        run_phase(20);
        check_val("t4_new", 64'(rsp_data[1*DW +: DW]), 64'(32'h0000_0055));

        // 5: three requesters held valid; rotation and fairness.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            push_op(0, 1'b0, 4'd8,  32'h0);
            push_op(1, 1'b0, 4'd9,  32'h0);
            push_op(2, 1'b0, 4'd10, 32'h0);
        end
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        run_cycle(1'b0);
        check_val("t5_pair0", 64'(last_rdy), 64'(4'b0011));
        run_cycle(1'b0);
        check_val("t5_pair1", 64'(last_rdy), 64'(4'b0101));
        run_cycle(1'b0);
        check_val("t5_pair2", 64'(last_rdy), 64'(4'b0110));
        run_phase(20);
        check_val("t5_starve", 64'(max_wait <= 1), 64'd1);

        // 6: reset right after a read is accepted discards it and clears ptr.
        do_reset();
        push_op(0, 1'b0, 4'd3, 32'h0);
        run_cycle(1'b0);
        check_val("t6_rdy_pre", 64'(last_rdy), 64'(4'b0001));
        push_op(0, 1'b0, 4'd8,  32'h0);
        push_op(2, 1'b0, 4'd9,  32'h0);
        push_op(3, 1'b0, 4'd10, 32'h0);
        run_cycle(1'b1);
        check_val("t6_rst_rdy", 64'(last_rdy), 64'd0);
        check_val("t6_rst_ram", 64'(last_ram_any), 64'd0);
        run_cycle(1'b1);
        run_cycle(1'b0);
        check_val("t6_ptr0", 64'(last_rdy), 64'(4'b0101));
        run_phase(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
